// File: rtl/periph_bus_pkg.sv
// Shared encodings for the two-master peripheral bus arbiter: grant states,
// master IDs and the peripheral register address map.
package periph_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } parb_state_e;

  localparam logic MID_M0 = 1'b0;
  localparam logic MID_M1 = 1'b1;

  localparam logic [31:0] ADDR_TH     = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL     = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON   = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED    = 32'h4000_000C;
  localparam logic [31:0] ADDR_SWITCH = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGI   = 32'h4000_0014;

endpackage

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing one single-word peripheral bus between two masters.
// Optional PARB_LOCK_EN lets master 1 hold the grant for up to LOCK_MAX transfers.
module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              per_rd,
  output logic              per_wr,
  output logic [ADDR_W-1:0] per_addr,
  output logic [DATA_W-1:0] per_wdata,
  input  logic [DATA_W-1:0] per_rdata
);

  parb_state_e r_state, w_state_nxt;
  logic        r_last, w_last_nxt;
  logic        w_hold1;

`ifdef PARB_LOCK_EN
  localparam int LCW = $clog2(LOCK_MAX) + 1;
  logic [LCW-1:0] r_lock_cnt;

  // Hold only while this locked transfer keeps the run below LOCK_MAX.
  assign w_hold1 = m1_req & m1_lock & ((int'(r_lock_cnt) + 1) < LOCK_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_lock_cnt <= '0;
    else if (r_state != OWN1 || w_state_nxt != OWN1 || !m1_lock)
      r_lock_cnt <= '0;
    else if (m1_req && int'(r_lock_cnt) < LOCK_MAX)
      r_lock_cnt <= r_lock_cnt + LCW'(1);
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = m1_lock;
  assign w_hold1       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_last  <= MID_M1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (m0_req && m1_req)
          w_state_nxt = (r_last == MID_M0) ? OWN1 : OWN0;
        else if (m0_req)
          w_state_nxt = OWN0;
        else if (m1_req)
          w_state_nxt = OWN1;
      end
      OWN0: begin
        if (m0_req) w_last_nxt = MID_M0;
        if (m1_req)      w_state_nxt = OWN1;
        else if (m0_req) w_state_nxt = OWN0;
        else             w_state_nxt = IDLE;
      end
      OWN1: begin
        if (m1_req) w_last_nxt = MID_M1;
        if (w_hold1)     w_state_nxt = OWN1;
        else if (m0_req) w_state_nxt = OWN0;
        else if (m1_req) w_state_nxt = OWN1;
        else             w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bus is steered straight from the owner's inputs; IDLE drives all zeros.
  always_comb begin
    per_rd    = 1'b0;
    per_wr    = 1'b0;
    per_addr  = '0;
    per_wdata = '0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    case (r_state)
      OWN0: begin
        per_addr  = m0_addr;
        per_wdata = m0_wdata;
        per_rd    = m0_req & ~m0_wr;
        per_wr    = m0_req & m0_wr;
        m0_ack    = m0_req;
        m0_rdata  = m0_req ? per_rdata : '0;
      end
      OWN1: begin
        per_addr  = m1_addr;
        per_wdata = m1_wdata;
        per_rd    = m1_req & ~m1_wr;
        per_wr    = m1_req & m1_wr;
        m1_ack    = m1_req;
        m1_rdata  = m1_req ? per_rdata : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: directed scenarios plus random traffic against
// a transaction-level grant model and a shadow copy of the peripheral contents.
module tb_periph_bus_arbiter;
  import periph_bus_pkg::*;

  localparam int TB_LOCK_MAX = 4;

  logic        clk, reset;
  logic [1:0]  req, wr;
  logic        lock;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        m0_ack, m1_ack, per_rd, per_wr;
  logic [31:0] m0_rdata, m1_rdata, per_addr, per_wdata, per_rdata;

  periph_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(TB_LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_wr(wr[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_wr(wr[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_lock(lock), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .per_rd(per_rd), .per_wr(per_wr), .per_addr(per_addr), .per_wdata(per_wdata),
    .per_rdata(per_rdata)
  );

  int n_vec = 0, n_err = 0;

  function automatic int pidx(input logic [31:0] a);
    return int'({a[30], a[6:2]});
  endfunction

  // Peripheral stand-in: combinational read, write commits at the rising edge.
  logic [31:0] pmem [64];
  logic [31:0] shadow [64];
  assign per_rdata = pmem[pidx(per_addr)];

  initial begin
    for (int i = 0; i < 64; i++) pmem[i] = '0;
    pmem[pidx(ADDR_SWITCH)] = 32'hA5;
    forever begin
      @(posedge clk);
      if (per_wr) pmem[pidx(per_addr)] = per_wdata;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the bus (-1 none), who was served last, lock run length.
  int          mown, mlast, mlc;
  logic [1:0]  acked, obs_ack;
  logic [31:0] obs_rd0;

  task automatic model_reset();
    mown = -1; mlast = 1; mlc = 0; acked = '0;
  endtask

  task automatic cycle();
    logic [1:0]  e_ack;
    logic        e_rd, e_wr, served, hold;
    logic [31:0] e_addr, e_wd;
    logic [31:0] e_rdat [2];
    int          o, nown;
    @(negedge clk);
    e_ack = '0; e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
    e_rdat[0] = '0; e_rdat[1] = '0;
    served = (mown >= 0) && req[mown];
    if (mown >= 0) begin
      e_addr = addr[mown];
      e_wd   = wdata[mown];
      if (served) begin
        e_ack[mown]  = 1'b1;
        e_rd         = ~wr[mown];
        e_wr         = wr[mown];
        e_rdat[mown] = shadow[pidx(addr[mown])];
      end
    end
    obs_ack = {m1_ack, m0_ack};
    obs_rd0 = m0_rdata;
    chk("ack",     32'(obs_ack),         32'(e_ack));
    chk("strobe",  32'({per_rd, per_wr}), 32'({e_rd, e_wr}));
    chk("addr",    per_addr,  e_addr);
    chk("wdata",   per_wdata, e_wd);
    chk("rdata0",  m0_rdata,  e_rdat[0]);
    chk("rdata1",  m1_rdata,  e_rdat[1]);
    acked = e_ack;
    if (served && wr[mown]) shadow[pidx(addr[mown])] = wdata[mown];
    if (mown < 0) begin
      if (req[0] && req[1]) nown = 1 - mlast;
      else if (req[0])      nown = 0;
      else if (req[1])      nown = 1;
      else                  nown = -1;
    end else begin
      o = 1 - mown;
      if (served) mlast = mown;
      hold = 1'b0;
`ifdef PARB_LOCK_EN
      if (mown == 1) begin
        if (!lock) mlc = 0;
        else if (served && mlc < TB_LOCK_MAX) mlc = mlc + 1;
        hold = served && lock && (mlc < TB_LOCK_MAX);
      end
`endif
      if (hold)           nown = 1;
      else if (req[o])    nown = o;
      else if (req[mown]) nown = mown;
      else                nown = -1;
    end
    if (nown != 1) mlc = 0;
    mown = nown;
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    req[m] = r; wr[m] = w; addr[m] = a; wdata[m] = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_m(0, 0, 0, '0, '0);
    set_m(1, 0, 0, '0, '0);
    lock = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
  endtask

  logic [31:0] atab [14];
  int          nacks;

  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = '0;
    shadow[pidx(ADDR_SWITCH)] = 32'hA5;
    for (int i = 0; i < 8; i++) atab[i] = 32'(i * 4);
    atab[8] = ADDR_TH;  atab[9] = ADDR_TL;   atab[10] = ADDR_TCON;
    atab[11] = ADDR_LED; atab[12] = ADDR_DIGI; atab[13] = ADDR_SWITCH;

    reset = 1'b0;
    set_m(0, 0, 0, '0, '0);
    set_m(1, 0, 0, '0, '0);
    lock = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_out", 32'({m0_ack, m1_ack, per_rd, per_wr}), 32'd0);
    chk("rst_addr", per_addr, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single read of the switch register
    set_m(0, 1, 0, ADDR_SWITCH, '0);
    cycle();
    chk("s1_noack", 32'(obs_ack), 32'd0);
    cycle();
    chk("s1_ack", 32'(obs_ack), 32'b01);
    chk("s1_rdata", obs_rd0, 32'hA5);
    set_m(0, 0, 0, '0, '0);
    cycle();
    cycle();

    // Simultaneous writes from reset: m0 first, then m1
    do_reset();
    set_m(0, 1, 1, ADDR_LED, 32'h3C);
    set_m(1, 1, 1, ADDR_DIGI, 32'h123);
    cycle();
    cycle();
    chk("s2_first", 32'(obs_ack), 32'b01);
    set_m(0, 0, 0, '0, '0);
    cycle();
    chk("s2_second", 32'(obs_ack), 32'b10);
    set_m(1, 0, 0, '0, '0);
    cycle();
    cycle();
    chk("s2_led", pmem[pidx(ADDR_LED)], 32'h3C);
    chk("s2_digi", pmem[pidx(ADDR_DIGI)], 32'h123);

    // m1 streams 8 writes then reads them back, one per cycle
    nacks = 0;
    set_m(1, 1, 1, 32'h0, 32'h1000);
    cycle();
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (obs_ack[1]) nacks++;
      if (i < 7) set_m(1, 1, 1, 32'((i + 1) * 4), 32'h1000 + 32'(i + 1));
      else       set_m(1, 1, 0, 32'h0, '0);
    end
    chk("s3_stream", 32'(nacks), 32'd8);
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i < 7) set_m(1, 1, 0, 32'((i + 1) * 4), '0);
      else       set_m(1, 0, 0, '0, '0);
    end
    cycle();
    for (int i = 0; i < 8; i++) chk("s3_mem", pmem[i], 32'h1000 + 32'(i));

    // Withdrawal while owning the bus
    set_m(1, 1, 1, ADDR_TL, 32'h77);
    cycle();
    set_m(1, 0, 1, ADDR_TL, 32'h77);
    cycle();
    chk("s4_noack", 32'(obs_ack), 32'd0);
    cycle();
    chk("s4_tl", pmem[pidx(ADDR_TL)], 32'd0);

    // Reset asserted mid-cycle during an m1 write to TH
    set_m(1, 1, 1, ADDR_TH, 32'hDEAD);
    cycle();
    @(negedge clk);
    chk("s5_wr_on", 32'(per_wr), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("s5_wr_off", 32'({per_wr, m1_ack}), 32'd0);
    @(posedge clk);
    #1;
    set_m(1, 0, 0, '0, '0);
    model_reset();
    reset = 1'b1;
    chk("s5_th", pmem[pidx(ADDR_TH)], 32'd0);
    set_m(0, 1, 0, ADDR_LED, '0);
    set_m(1, 1, 0, ADDR_DIGI, '0);
    lock = 1'b1;
    cycle();
    // Both held with m1_lock set for a while
    for (int i = 0; i < 12; i++) cycle();
    set_m(0, 0, 0, '0, '0);
    set_m(1, 0, 0, '0, '0);
    lock = 1'b0;
    cycle();
    cycle();

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (acked[m] || !req[m]) begin
          if ($urandom_range(0, 3) != 0)
            set_m(m, 1, 1'($urandom_range(0, 1)), atab[$urandom_range(0, 13)], $urandom);
          else
            req[m] = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          req[m] = 1'b0;
        end
      end
      lock = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
Two-master arbiter that shares the single peripheral/data-memory bus (rd, wr, addr, wdata, rdata) between the CPU data port (master 0) and a secondary requester such as a UART DMA engine (master 1). Uses a registered grant state machine with round-robin fairness. Exactly one single-word access is issued per granted cycle. Sits between the masters and the Peripheral block; the Peripheral is unchanged.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
LOCK_MAX, 16, maximum consecutive locked transfers (used only with PARB_LOCK_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
m0_req  in  1  master 0 access request; held until m0_ack
m0_wr  in  1  1 = write, 0 = read
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_ack  out  1  one-cycle transfer-done pulse
m0_rdata  out  DATA_W  read data, valid only while m0_ack=1
m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0_* for master 1
m1_lock  in  1  keep the grant after this transfer (ignored without PARB_LOCK_EN)
per_rd  out  1  bus read strobe
per_wr  out  1  bus write strobe
per_addr  out  ADDR_W  bus address
per_wdata  out  DATA_W  bus write data
per_rdata  in  DATA_W  bus read data (combinational from the Peripheral)

Behaviour:
- State register: IDLE, OWN0, OWN1. Round-robin pointer `last` (1 bit).
- Reset (asynchronous, while reset=0): state=IDLE, last=1 so master 0 wins the first tie. All outputs are 0 immediately.
- IDLE: no bus activity. Next state:
  - only m0_req → OWN0; only m1_req → OWN1
  - both → OWN(~last)
  - none → stay IDLE
- OWNx, combinational outputs:
  - per_addr = mx_addr, per_wdata = mx_wdata
  - per_rd = mx_req & ~mx_wr; per_wr = mx_req & mx_wr
  - mx_ack = mx_req
  - mx_rdata = per_rdata when mx_ack=1, else 0
  - Write commits at the next rising clk inside the Peripheral.
- OWNx, next state:
  - if mx_req was served, last ← x
  - other master requesting → OWN(other)
  - else mx_req → stay OWNx (back-to-back)
  - else → IDLE
- mx_req low while in OWNx (withdrawn): no strobe, no ack; normal next-state rules apply.
- Latency: request from IDLE is acked 1 cycle after req rises. Sustained single master: 1 transfer/cycle. Both masters contending: strict alternation, so each master is acked at most 2 cycles after its request is presented while in OWN.
- Non-granted master: ack=0, rdata=0. Bus outputs are all 0 in IDLE.
- Masters hold req/wr/addr/wdata stable until ack. Changing them earlier is illegal and not checked.
- Reset mid-transfer: strobes drop asynchronously. An in-flight write is not committed unless the clk edge has already occurred.

Optional Feature:
- Macro PARB_LOCK_EN.
- Defined:
  - A 5-bit (clog2(LOCK_MAX)+1) counter lock_cnt counts consecutive OWN1 transfers with m1_lock=1.
  - While m1_lock=1 and lock_cnt < LOCK_MAX, OWN1 stays OWN1 even if m0_req=1.
  - When lock_cnt reaches LOCK_MAX with m0_req=1, the grant passes to OWN0.
  - lock_cnt clears on leaving OWN1, on m1_lock=0, and on reset.
- Undefined: m1_lock is ignored, no counter is built, pure round-robin.

Decomposition:
- Package periph_bus_pkg holds:
  - state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2)
  - master IDs
  - peripheral address map constants: TH 0x40000000, TL 0x40000004, TCON 0x40000008, LED 0x4000000C, SWITCH 0x40000010, DIGI 0x40000014
- No sub-module; the arbiter is a single flat module.

Test Plan:
- Single read: after reset, m0 reads 0x40000010 with switch=0xA5 → m0_ack high exactly 1 cycle, one cycle after req; m0_rdata=0x000000A5; m1_ack=0.
- Simultaneous requests from reset: m0 writes 0x4000000C=0x3C, m1 writes 0x40000014=0x123, both held → m0 acked in cycle 1, m1 in cycle 2; LED=0x3C, digi=0x123; return to IDLE.
- Sustained single master: m1 streams 8 writes to data memory 0x00–0x1C, m0 idle → 8 consecutive m1_ack pulses with no gaps; memory read-back matches.
- Withdrawal: m1_req drops during OWN1 → per_rd=per_wr=0, no ack, IDLE next cycle.
- Reset mid-write: reset=0 asserted mid-cycle during OWN1 write to TH → per_wr falls immediately; TH stays 0; state is IDLE after reset release.
- Lock (PARB_LOCK_EN, LOCK_MAX=4): m1_req=m1_lock=1 and m0_req=1 held → 4 consecutive m1 acks, then m0 acked; without the macro the same stimulus alternates m0, m1, m0, ...
